// File: rtl/case_conv_stream.sv
`default_nettype none
// ============================================================================
// case_conv_stream : FIFO-fed sequencer around a slow combinational uppercase
//                    converter; captures each result onto a valid/ready output.
// Revision         : 1.0
// ============================================================================
module case_conv_stream #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 5,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic [7:0]       conv_in,
    input  logic [7:0]       conv_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             busy,
    output logic [CNT_W-1:0] changed_count
);
    localparam int c_ADDR_W   = $clog2(DEPTH);
    localparam int c_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_mem [DEPTH];
    logic [c_ADDR_W:0]     r_wr_ptr;
    logic [c_ADDR_W:0]     r_rd_ptr;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [7:0]            r_conv_in;
    logic [7:0]            r_out_data;
    logic                  r_out_valid;
    logic [CNT_W-1:0]      r_changed_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_capture;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_push  = in_valid && !w_full;

    assign in_ready      = !w_full;
    assign busy          = (r_state != S_IDLE) || !w_empty;
    assign conv_in       = r_conv_in;
    assign out_data      = r_out_data;
    assign out_valid     = r_out_valid;
    assign changed_count = r_changed_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pop decisions use the registered empty flag, so a same-edge write is
    // never visible to the load that happens on that edge.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_settle_cnt    <= '0;
            r_conv_in       <= 8'h00;
            r_out_data      <= 8'h00;
            r_out_valid     <= 1'b0;
            r_changed_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_conv_in    <= r_mem[r_rd_ptr[c_ADDR_W-1:0]];
                r_settle_cnt <= c_SETTLE_LOAD;
            end else if ((r_state == S_SETTLE) && (r_settle_cnt != '0)) begin
                r_settle_cnt <= r_settle_cnt - 1'b1;
            end

            if (w_capture) begin
                r_out_data  <= conv_out;
                r_out_valid <= 1'b1;
                if ((conv_out != r_conv_in) && (r_changed_count != '1)) begin
                    r_changed_count <= r_changed_count + 1'b1;
                end
            end else if ((r_state == S_HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_case_conv_stream.sv
`default_nettype none
// ============================================================================
// tb_case_conv_stream : directed + random bench with a queue-based model and
//                       a slow-settling converter model for case_conv_stream.
// Revision            : 1.0
// ============================================================================
module tb_case_conv_stream;
    localparam int SETTLE = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  conv_in;
    logic [7:0]  conv_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic [15:0] changed_count;

    logic        in2_valid;
    logic        in2_ready;
    logic [7:0]  in2_data;
    logic [7:0]  conv_in2;
    logic [7:0]  conv_out2;
    logic        out2_valid;
    logic        out2_ready;
    logic [7:0]  out2_data;
    logic        busy2;
    logic [1:0]  count2;

    always #10 clk = ~clk;

    case_conv_stream #(.DEPTH(4), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .conv_in(conv_in), .conv_out(conv_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .changed_count(changed_count)
    );

    case_conv_stream #(.DEPTH(4), .SETTLE_CYCLES(SETTLE), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready),
        .in_data(in2_data), .conv_in(conv_in2), .conv_out(conv_out2),
        .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data),
        .busy(busy2), .changed_count(count2)
    );

    function automatic logic [7:0] upper(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) ? (b - 8'h20) : b;
    endfunction

    // Slow converter: output is garbage until its input has been stable
    // for SETTLE-1 falling edges, so an early capture shows up as bad data.
    logic [7:0] prev_conv_in = 8'h00;
    int         conv_age     = 100;
    always @(negedge clk) begin
        if (conv_in !== prev_conv_in) conv_age <= 0;
        else if (conv_age < 100)      conv_age <= conv_age + 1;
        prev_conv_in <= conv_in;
    end
    assign conv_out   = (conv_age >= SETTLE - 1) ? upper(conv_in) : ~upper(conv_in);
    assign conv_out2  = upper(conv_in2);
    assign out2_ready = 1'b1;

    logic [7:0] exp_q[$];
    int         cnt_model    = 0;
    int         n_out        = 0;
    int         total        = 0;
    int         bad          = 0;
    logic       hold_pending = 1'b0;
    logic [7:0] hold_data    = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: account for the handshakes the coming edge performs, then advance.
    task automatic cycle();
        logic [7:0] b;
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_data", 32'(out_data), 32'(hold_data));
        end
        hold_pending = out_valid && !out_ready;
        hold_data    = out_data;
        if (in_valid && in_ready) exp_q.push_back(in_data);
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_out observed=0x%0h expected=none", out_data);
            end else begin
                b = exp_q.pop_front();
                if ((b != upper(b)) && (cnt_model < 65535)) cnt_model++;
                check("out_data", 32'(out_data), 32'(upper(b)));
                check("changed_count", 32'(changed_count), 32'(cnt_model));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int rdy_pct);
        int   n = 0;
        logic acc;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            out_ready = (int'($urandom_range(99)) < rdy_pct);
            acc = in_ready;
            cycle();
            n++;
        end while (!acc && (n < 200));
        in_valid = 1'b0;
        if (!acc) check("send_accept", 32'(acc), 32'(1));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (((exp_q.size() != 0) || busy) && (n < budget)) begin
            cycle();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'(0));
        check("drain_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        logic [7:0] t2[6];
        logic [7:0] t3[6];
        int         n;
        int         c0;
        logic       seen;
        logic [7:0] b;

        t2 = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h7A, 8'hE1};
        t3 = '{8'h71, 8'h52, 8'h33, 8'h64, 8'h7E, 8'h66};
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        in2_valid = 1'b0; in2_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_conv_in", 32'(conv_in), 32'h00);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_count", 32'(changed_count), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Single byte latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h61;
        cycle();
        in_valid = 1'b0;
        check("t1_no_bypass", 32'(conv_in), 32'h00);
        check("t1_busy", 32'(busy), 32'(1));
        cycle();
        check("t1_load", 32'(conv_in), 32'h61);
        n = 0;
        while (!out_valid && (n < 20)) begin cycle(); n++; end
        check("t1_latency", 32'(n), 32'(SETTLE));
        check("t1_data", 32'(out_data), 32'h41);
        check("t1_count", 32'(changed_count), 32'(1));
        drain(20);

        // Boundary characters around the lowercase range
        c0 = int'(changed_count);
        foreach (t2[i]) send(t2[i], 100);
        drain(100);
        check("t2_count_delta", 32'(int'(changed_count) - c0), 32'(1));

        // Random stream with random backpressure and gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(3) == 0) begin
                in_valid  = 1'b0;
                out_ready = $urandom_range(1) == 1;
                cycle();
            end
            b = ($urandom_range(1) == 1) ? 8'(8'h61 + $urandom_range(25)) : 8'($urandom_range(255));
            send(b, 60);
        end
        drain(500);

        // Backpressure fills the FIFO; the sixth byte is refused
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = t3[i];
            check("t3_ready_open", 32'(in_ready), 32'(1));
            cycle();
        end
        in_data = t3[5];
        for (int i = 0; i < 10; i++) begin
            check("t3_ready_full", 32'(in_ready), 32'(0));
            cycle();
        end
        n_out = 0;
        drain(200);
        check("t3_n_out", 32'(n_out), 32'(5));

        // Write on the same edge as a handshake into an empty FIFO
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h62;
        cycle();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && (n < 20)) begin cycle(); n++; end
        check("t4_valid", 32'(out_valid), 32'(1));
        in_valid = 1'b1;
        in_data  = 8'h63;
        cycle();
        in_valid = 1'b0;
        check("t4_not_loaded", 32'(conv_in), 32'h62);
        check("t4_busy", 32'(busy), 32'(1));
        cycle();
        check("t4_loaded", 32'(conv_in), 32'h63);
        drain(50);

        // Reset during SETTLE with two bytes queued
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 8'h71; cycle();
        in_data = 8'h72; cycle();
        in_data = 8'h73; cycle();
        in_valid = 1'b0;
        check("t5_settle_conv_in", 32'(conv_in), 32'h71);
        rst = 1'b1;
        #1;
        check("t5_out_valid", 32'(out_valid), 32'(0));
        check("t5_conv_in", 32'(conv_in), 32'h00);
        check("t5_out_data", 32'(out_data), 32'h00);
        check("t5_count", 32'(changed_count), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        exp_q.delete();
        cnt_model    = 0;
        hold_pending = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t5_in_ready", 32'(in_ready), 32'(1));
        n_out = 0;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            seen = seen | out_valid;
            cycle();
        end
        check("t5_no_valid", 32'(seen), 32'(0));
        check("t5_busy_after", 32'(busy), 32'(0));

        // Narrow counter saturation
        for (int k = 0; k < 5; k++) begin
            b = 8'(8'h61 + $urandom_range(25));
            check("t6_in_ready", 32'(in2_ready), 32'(1));
            in2_valid = 1'b1;
            in2_data  = b;
            @(posedge clk);
            #1;
            in2_valid = 1'b0;
            n = 0;
            while (!out2_valid && (n < 30)) begin @(posedge clk); #1; n++; end
            check("t6_data", 32'(out2_data), 32'(upper(b)));
            check("t6_count", 32'(count2), 32'((k + 1 < 3) ? k + 1 : 3));
            @(posedge clk);
            #1;
        end
        check("t6_busy", 32'(busy2), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/case_conv_stream.md
Name: case_conv_stream

Overview:
- Sequential wrapper that sits directly upstream of the gate-level uppercase converter and also captures its result.
- Buffers incoming ASCII bytes in a small FIFO and drives one byte at a time onto the converter input.
- Waits a fixed number of cycles for the converter's gate delays to settle, then registers the converted byte and presents it on a valid/ready output.
- Counts how many characters the converter actually changed.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- SETTLE_CYCLES, 5: cycles between driving conv_in and capturing conv_out. Must be at least 1. The default covers the converter's worst-case path of 85 ns at a 20 ns clock.
- CNT_W, 16: width of changed_count.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream byte valid
- in_ready  out  1  FIFO can accept a byte
- in_data  in  8  upstream ASCII byte
- conv_in  out  8  registered byte driven into the converter
- conv_out  in  8  converter result (combinational, slow)
- out_valid  out  1  out_data holds a converted byte
- out_ready  in  1  downstream accepts out_data
- out_data  out  8  registered converted byte
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- changed_count  out  CNT_W  saturating count of bytes where the converted value differs from the original

Behaviour:

Reset (asynchronous, active-high):
- Values held while rst is high: FIFO empty, state IDLE, conv_in=0x00, out_data=0x00, out_valid=0, changed_count=0, settle counter=0.
- Outputs: in_ready=1 once rst falls; busy=0.
- Assertion mid-operation discards all buffered and in-flight bytes. Nothing is emitted afterwards for those bytes.

FIFO:
- Write occurs on an edge where in_valid & in_ready.
- in_ready = !full. The value is registered-state derived and has no combinational path from out_ready.
- A write and a pop on the same edge are both performed; occupancy is unchanged.
- Writes are ignored when full, since in_ready=0. There is no bypass path from in_data to conv_in.
- Pointers wrap modulo DEPTH.

FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - If the FIFO is non-empty: at the edge, conv_in <= head, pop, settle counter <= SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - conv_in is held stable.
  - If the counter is nonzero, decrement it.
  - If the counter is zero: at the edge, out_data <= conv_out, out_valid <= 1, update changed_count, go to HOLD.
- HOLD:
  - out_valid=1, and out_data is held stable until the handshake.
  - On an edge with out_ready=1: out_valid <= 0. Then, if the FIFO is non-empty (evaluated before any same-edge write), load the next head into conv_in, pop, and go to SETTLE. Otherwise go to IDLE.
  - Consequence: a byte written on the same edge as the handshake into an empty FIFO is loaded on the following edge.
  - With out_ready=0, the FSM stays in HOLD indefinitely. The FIFO keeps filling until full.

Latency:
- A byte written at edge E into an empty FIFO while the block is IDLE is loaded at edge E+1.
- out_valid rises after edge E+1+SETTLE_CYCLES.
- Back-to-back throughput with out_ready tied high: one byte every SETTLE_CYCLES+1 cycles.

changed_count:
- Increments by 1 at capture when conv_out != conv_in.
- Saturates at 2^CNT_W-1 and does not wrap.
- Cleared only by reset.

busy:
- busy = (state != IDLE) | !empty.

Test Plan:
1. Idle block, write 0x61 ('a'), out_ready=1 → conv_in=0x61 one cycle after the write. out_valid rises 6 cycles after the write edge with out_data=0x41; changed_count=1.
2. Stream 0x40, 0x5B, 0x60, 0x7B, 0x7A, 0xE1 → outputs 0x40, 0x5B, 0x60, 0x7B, 0x5A, 0xE1 in order; changed_count=1.
3. Hold out_ready=0 and write 6 bytes with DEPTH=4 → first byte captured to HOLD and next 4 fill the FIFO. in_ready=0 while the 6th is offered, and the 6th is not accepted. After releasing out_ready, exactly 5 bytes appear in order.
4. With out_ready=1, write a new byte on the same edge as an output handshake while the FIFO is empty → FSM passes through IDLE. The next conv_in load happens one cycle later.
5. Assert rst for one cycle mid-SETTLE with 2 bytes queued → all outputs return to reset values immediately. No further out_valid occurs; busy=0 after reset.
6. Set CNT_W=2 and send 5 lowercase bytes → changed_count reads 1, 2, 3, 3, 3.
